control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Microcoded control unit that sits directly upstream of memory_system.
- Drives every control input of memory_system: IR/MAR clears and enables, ALU op and flag enable, bank read/write addresses, and memory/MDR controls.
- Consumes the datapath's instruction[4:0] and flags C/N/P/Z.
- Runs a fixed fetch/decode/execute FSM for a 5-bit opcode set on the 8-bit datapath.

Parameters:
- DATA_WIDTH, 8, datapath width; informational only, since no port depends on it.
- PC_ADDR, 3'b000, bank code of PC.
- DPTR_ADDR, 3'b010, bank code of DPTR.
- A_ADDR, 3'b011, bank code of A (fixed ALU operand A).
- MDR_ADDR, 3'b101, busB source code selecting MDR.
- ACC_ADDR, 3'b111, bank code of ACC.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instruction  in  5  IR contents from datapath.
- C, N, P, Z  in  1 each  registered ALU flags.
- ir_sclr, mar_sclr  out  1 each  synchronous clears of IR and MAR.
- enaf  out  1  flag register update enable.
- selop  out  3  ALU op: 000 pass B, 001 B+1, 010 A+B, 011 A-B, 100 AND, 101 OR, 110 XOR, 111 shift-left B by shamt.
- shamt  out  2  shift amount.
- bank_wr_en  out  1  register bank write enable.
- busB_addr, busC_addr  out  3 each  bank read and write selects.
- ir_en, mar_en, mdr_en  out  1 each  IR (from MDR), MAR (from busC), MDR load enables.
- wr_rdn  out  1  1 = memory write, 0 = read.
- mdr_alu_n  out  1  MDR source: 1 = memory, 0 = ALU.
- halted  out  1  high in HALT.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.

Behaviour:
- State register only; all outputs are a Moore decode of state, plus IR and flags for jumps.
- Every output defaults to 0 in every state unless listed below.
- States: INIT, F0, F1, F2, DEC, EX1, EX2, EX3, HALT.
- Reset: rst=1 at a clock edge forces state to INIT, including mid-instruction, in HALT, or mid-store (no write is completed).
- INIT: ir_sclr=mar_sclr=1; next F0. This gives the following reset values: ir_sclr=mar_sclr=1, all other outputs 0.
- F0: busB=PC, selop=000, mar_en=1.
- F1: memory read (wr_rdn=0, mdr_alu_n=1, mdr_en=1) and, in parallel, PC<=PC+1 (busB=busC=PC, selop=001, bank_wr_en=1).
- F2: ir_en=1.
- DEC: sample the opcode. Jumps resolve here. HALT, NOP and illegal opcodes also finish here with instr_done=1.
- Opcodes and execution:
  - 00000 NOP: done in DEC.
  - 00001 MOV DPTR,ACC: EX1 busB=ACC, busC=DPTR, selop=000, bank_wr_en=1.
  - 00010 MOV ACC,DPTR: EX1, operands reversed.
  - 00011 MOV A,ACC: EX1, busB=ACC, busC=A.
  - 00100 LD ACC,[DPTR]:
    - EX1: busB=DPTR, selop=000, mar_en=1.
    - EX2: mdr_alu_n=1, mdr_en=1, wr_rdn=0.
    - EX3: busB=MDR_ADDR, busC=ACC, selop=000, bank_wr_en=1.
  - 00101 ST [DPTR],ACC:
    - EX1: as LD.
    - EX2: busB=ACC, selop=000, mdr_alu_n=0, mdr_en=1.
    - EX3: wr_rdn=1.
  - 00110..01010 ADD, SUB, AND, OR, XOR: EX1 busB=busC=ACC, selop=010..110, enaf=1, bank_wr_en=1; result ACC <= A op ACC.
  - 01011 SHL: same as ADD with selop=111, shamt=2'b01.
  - 01100 JZ, 01101 JC, 01110 JN:
    - Flag sampled in DEC, value as of the end of the previous instruction.
    - Taken: EX1 busB=DPTR, busC=PC, selop=000, bank_wr_en=1.
    - Not taken: done in DEC.
  - 11111 HALT: DEC goes to HALT. HALT holds with halted=1 and all other outputs 0 until rst.
  - Any other opcode: illegal=1 in DEC, then behaves as NOP.
- Transitions: last EX state goes to F0. Only LD and ST use EX2 and EX3.
- instr_done is high in the last EX state, or in DEC for NOP, illegal, HALT and untaken jumps.
- enaf is asserted only in ALU EX1; flags are unchanged by MOV, LD, ST and jumps.
- Latency per instruction: NOP, illegal and untaken jump 4 cycles; MOV, ALU and taken jump 5; LD and ST 7.

Test Plan:
- Reset: hold rst 2 cycles mid-EX2 of LD, then release -> INIT for 1 cycle (ir_sclr=mar_sclr=1), then F0 (mar_en=1, busB_addr=000). No bank_wr_en while rst=1.
- MOV DPTR,ACC: instruction=00001 -> EX1 has busB_addr=111, busC_addr=010, selop=000, bank_wr_en=1, enaf=0, instr_done=1. The cycle after is F0.
- ADD: instruction=00110 -> EX1 selop=010, enaf=1, bank_wr_en=1, busC_addr=111. Total 5 cycles from F0 to the next F0.
- ST: instruction=00101 -> EX2 has mdr_alu_n=0, mdr_en=1. EX3 has wr_rdn=1, and wr_rdn=0 in all other cycles. Total 7 cycles.
- JZ with Z=1 -> EX1 busB_addr=010, busC_addr=000, bank_wr_en=1. With Z=0 -> instr_done in DEC, next F0, no bank write.
- instruction=10000 -> illegal pulses 1 cycle in DEC. instruction=11111 -> halted=1 and stays high for 10 cycles with all controls 0; rst then returns to INIT.

Source files
------------

// File: rtl/control_sequencer.sv
// ============================================================================
// Module      : control_sequencer
// Description : Microcoded fetch/decode/execute control unit that drives
//               every control input of memory_system from the IR opcode and
//               the registered ALU flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer #(
  parameter int         DATA_WIDTH = 8,
  parameter logic [2:0] PC_ADDR    = 3'b000,
  parameter logic [2:0] DPTR_ADDR  = 3'b010,
  parameter logic [2:0] A_ADDR     = 3'b011,
  parameter logic [2:0] MDR_ADDR   = 3'b101,
  parameter logic [2:0] ACC_ADDR   = 3'b111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] instruction,
  input  logic       C,
  input  logic       N,
  input  logic       P,
  input  logic       Z,
  output logic       ir_sclr,
  output logic       mar_sclr,
  output logic       enaf,
  output logic [2:0] selop,
  output logic [1:0] shamt,
  output logic       bank_wr_en,
  output logic [2:0] busB_addr,
  output logic [2:0] busC_addr,
  output logic       ir_en,
  output logic       mar_en,
  output logic       mdr_en,
  output logic       wr_rdn,
  output logic       mdr_alu_n,
  output logic       halted,
  output logic       illegal,
  output logic       instr_done
);

  localparam logic [4:0] OP_NOP      = 5'b00000;
  localparam logic [4:0] OP_MOV_DA   = 5'b00001;
  localparam logic [4:0] OP_MOV_AD   = 5'b00010;
  localparam logic [4:0] OP_MOV_AACC = 5'b00011;
  localparam logic [4:0] OP_LD       = 5'b00100;
  localparam logic [4:0] OP_ST       = 5'b00101;
  localparam logic [4:0] OP_ADD      = 5'b00110;
  localparam logic [4:0] OP_SUB      = 5'b00111;
  localparam logic [4:0] OP_AND      = 5'b01000;
  localparam logic [4:0] OP_OR       = 5'b01001;
  localparam logic [4:0] OP_XOR      = 5'b01010;
  localparam logic [4:0] OP_SHL      = 5'b01011;
  localparam logic [4:0] OP_JZ       = 5'b01100;
  localparam logic [4:0] OP_JC       = 5'b01101;
  localparam logic [4:0] OP_JN       = 5'b01110;
  localparam logic [4:0] OP_HALT     = 5'b11111;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_INC  = 3'b001;

  typedef enum logic [3:0] {
    S_INIT = 4'd0,
    S_F0   = 4'd1,
    S_F1   = 4'd2,
    S_F2   = 4'd3,
    S_DEC  = 4'd4,
    S_EX1  = 4'd5,
    S_EX2  = 4'd6,
    S_EX3  = 4'd7,
    S_HALT = 4'd8
  } state_t;

  state_t state;

  logic       is_mov;
  logic       is_mem;
  logic       is_alu;
  logic       is_jmp;
  logic       is_halt;
  logic       is_legal;
  logic       jump_taken;
  logic       needs_ex;
  logic [2:0] alu_op;

  // The parity flag and the datapath width are part of the interface but no
  // opcode in this set depends on them.
  logic unused_cfg;
  assign unused_cfg = &{1'b0, P, (DATA_WIDTH > 0)};

  // Opcode classification; IR is stable from DEC until the next F2.
  always_comb begin
    is_mov     = (instruction == OP_MOV_DA) || (instruction == OP_MOV_AD) ||
                 (instruction == OP_MOV_AACC);
    is_mem     = (instruction == OP_LD) || (instruction == OP_ST);
    is_alu     = (instruction >= OP_ADD) && (instruction <= OP_SHL);
    is_jmp     = (instruction >= OP_JZ) && (instruction <= OP_JN);
    is_halt    = (instruction == OP_HALT);
    is_legal   = (instruction <= OP_JN) || is_halt;
    jump_taken = ((instruction == OP_JZ) && Z) ||
                 ((instruction == OP_JC) && C) ||
                 ((instruction == OP_JN) && N);
    needs_ex   = is_mov || is_mem || is_alu || jump_taken;
    alu_op     = ALU_PASS;
    case (instruction)
      OP_ADD:  alu_op = 3'b010;
      OP_SUB:  alu_op = 3'b011;
      OP_AND:  alu_op = 3'b100;
      OP_OR:   alu_op = 3'b101;
      OP_XOR:  alu_op = 3'b110;
      OP_SHL:  alu_op = 3'b111;
      default: alu_op = ALU_PASS;
    endcase
  end

  // State register: fetch, decode, then up to three execute cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
    end else begin
      case (state)
        S_INIT: state <= S_F0;
        S_F0:   state <= S_F1;
        S_F1:   state <= S_F2;
        S_F2:   state <= S_DEC;
        S_DEC: begin
          if (is_halt)       state <= S_HALT;
          else if (needs_ex) state <= S_EX1;
          else               state <= S_F0;
        end
        S_EX1:  state <= is_mem ? S_EX2 : S_F0;
        S_EX2:  state <= S_EX3;
        S_EX3:  state <= S_F0;
        S_HALT: state <= S_HALT;
        default: state <= S_INIT;
      endcase
    end
  end

  // Moore output decode; only DEC looks at the flags (jump resolution).
  always_comb begin
    ir_sclr    = 1'b0;
    mar_sclr   = 1'b0;
    enaf       = 1'b0;
    selop      = ALU_PASS;
    shamt      = 2'b00;
    bank_wr_en = 1'b0;
    busB_addr  = 3'b000;
    busC_addr  = 3'b000;
    ir_en      = 1'b0;
    mar_en     = 1'b0;
    mdr_en     = 1'b0;
    wr_rdn     = 1'b0;
    mdr_alu_n  = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;
    instr_done = 1'b0;
    case (state)
      S_INIT: begin
        ir_sclr  = 1'b1;
        mar_sclr = 1'b1;
      end
      S_F0: begin
        busB_addr = PC_ADDR;
        mar_en    = 1'b1;
      end
      S_F1: begin
        // Memory read into MDR while PC is incremented through the ALU.
        mdr_alu_n  = 1'b1;
        mdr_en     = 1'b1;
        busB_addr  = PC_ADDR;
        busC_addr  = PC_ADDR;
        selop      = ALU_INC;
        bank_wr_en = 1'b1;
      end
      S_F2: begin
        ir_en = 1'b1;
      end
      S_DEC: begin
        illegal    = !is_legal;
        instr_done = !needs_ex;
      end
      S_EX1: begin
        if (is_mov) begin
          bank_wr_en = 1'b1;
          instr_done = 1'b1;
          case (instruction)
            OP_MOV_DA: begin busB_addr = ACC_ADDR;  busC_addr = DPTR_ADDR; end
            OP_MOV_AD: begin busB_addr = DPTR_ADDR; busC_addr = ACC_ADDR;  end
            default:   begin busB_addr = ACC_ADDR;  busC_addr = A_ADDR;    end
          endcase
        end else if (is_mem) begin
          busB_addr = DPTR_ADDR;
          mar_en    = 1'b1;
        end else if (is_alu) begin
          busB_addr  = ACC_ADDR;
          busC_addr  = ACC_ADDR;
          selop      = alu_op;
          shamt      = (instruction == OP_SHL) ? 2'b01 : 2'b00;
          enaf       = 1'b1;
          bank_wr_en = 1'b1;
          instr_done = 1'b1;
        end else if (is_jmp) begin
          busB_addr  = DPTR_ADDR;
          busC_addr  = PC_ADDR;
          bank_wr_en = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_EX2: begin
        if (instruction == OP_LD) begin
          mdr_alu_n = 1'b1;
          mdr_en    = 1'b1;
        end else begin
          busB_addr = ACC_ADDR;
          mdr_en    = 1'b1;
        end
      end
      S_EX3: begin
        instr_done = 1'b1;
        if (instruction == OP_LD) begin
          busB_addr  = MDR_ADDR;
          busC_addr  = ACC_ADDR;
          bank_wr_en = 1'b1;
        end else begin
          wr_rdn = 1'b1;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        ir_sclr = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// Module      : tb_control_sequencer
// Description : Self-checking bench for control_sequencer; expected control
//               vectors are queued per cycle as stimulus is driven and
//               compared on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;

  typedef struct packed {
    logic       ir_sclr;
    logic       mar_sclr;
    logic       enaf;
    logic [2:0] selop;
    logic [1:0] shamt;
    logic       bank_wr_en;
    logic [2:0] busB;
    logic [2:0] busC;
    logic       ir_en;
    logic       mar_en;
    logic       mdr_en;
    logic       wr_rdn;
    logic       mdr_alu_n;
    logic       halted;
    logic       illegal;
    logic       instr_done;
  } ctl_t;

  logic       clk;
  logic       rst;
  logic [4:0] instruction;
  logic       C, N, P, Z;
  logic       ir_sclr, mar_sclr, enaf, bank_wr_en;
  logic [2:0] selop, busB_addr, busC_addr;
  logic [1:0] shamt;
  logic       ir_en, mar_en, mdr_en, wr_rdn, mdr_alu_n;
  logic       halted, illegal, instr_done;

  int   n_checks = 0;
  int   n_errors = 0;
  ctl_t exp_q[$];
  string tag_q[$];
  ctl_t obs;

  control_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .instruction(instruction),
    .C          (C),
    .N          (N),
    .P          (P),
    .Z          (Z),
    .ir_sclr    (ir_sclr),
    .mar_sclr   (mar_sclr),
    .enaf       (enaf),
    .selop      (selop),
    .shamt      (shamt),
    .bank_wr_en (bank_wr_en),
    .busB_addr  (busB_addr),
    .busC_addr  (busC_addr),
    .ir_en      (ir_en),
    .mar_en     (mar_en),
    .mdr_en     (mdr_en),
    .wr_rdn     (wr_rdn),
    .mdr_alu_n  (mdr_alu_n),
    .halted     (halted),
    .illegal    (illegal),
    .instr_done (instr_done)
  );

  assign obs = {ir_sclr, mar_sclr, enaf, selop, shamt, bank_wr_en, busB_addr,
                busC_addr, ir_en, mar_en, mdr_en, wr_rdn, mdr_alu_n, halted,
                illegal, instr_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [22:0] got,
                           input logic [22:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: one expected vector per clock cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ctl_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_val(t, obs, e);
    end
  end

  // Queue the expectation for the current cycle, then advance one clock.
  task automatic step(input string tag, input ctl_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  function automatic ctl_t v_init();
    ctl_t v = '0;
    v.ir_sclr = 1'b1; v.mar_sclr = 1'b1;
    return v;
  endfunction

  function automatic ctl_t v_halt();
    ctl_t v = '0;
    v.halted = 1'b1;
    return v;
  endfunction

  task automatic fetch(input string nm);
    ctl_t v;
    v = '0; v.busB = 3'b000; v.mar_en = 1'b1;
    step({nm, ".F0"}, v);
    v = '0; v.mdr_alu_n = 1'b1; v.mdr_en = 1'b1; v.selop = 3'b001;
    v.busB = 3'b000; v.busC = 3'b000; v.bank_wr_en = 1'b1;
    step({nm, ".F1"}, v);
    v = '0; v.ir_en = 1'b1;
    step({nm, ".F2"}, v);
  endtask

  // Drives one complete instruction and queues its cycle-by-cycle controls.
  task automatic run_instr(input string nm, input logic [4:0] op,
                           input logic c_f, input logic n_f, input logic z_f);
    ctl_t v;
    logic taken;
    instruction = op; C = c_f; N = n_f; Z = z_f; P = ~z_f;
    fetch(nm);
    taken = (op == 5'b01100 && z_f) || (op == 5'b01101 && c_f) ||
            (op == 5'b01110 && n_f);
    v = '0;
    case (op)
      5'b00000, 5'b11111: v.instr_done = 1'b1;
      5'b01100, 5'b01101, 5'b01110: v.instr_done = !taken;
      default: begin
        if (op > 5'b01110) begin
          v.illegal = 1'b1; v.instr_done = 1'b1;
        end
      end
    endcase
    step({nm, ".DEC"}, v);
    v = '0;
    case (op)
      5'b00001: begin v.busB = 3'b111; v.busC = 3'b010; v.bank_wr_en = 1'b1;
                      v.instr_done = 1'b1; step({nm, ".EX1"}, v); end
      5'b00010: begin v.busB = 3'b010; v.busC = 3'b111; v.bank_wr_en = 1'b1;
                      v.instr_done = 1'b1; step({nm, ".EX1"}, v); end
      5'b00011: begin v.busB = 3'b111; v.busC = 3'b011; v.bank_wr_en = 1'b1;
                      v.instr_done = 1'b1; step({nm, ".EX1"}, v); end
      5'b00100, 5'b00101: begin
        v.busB = 3'b010; v.mar_en = 1'b1;
        step({nm, ".EX1"}, v);
        v = '0;
        if (op == 5'b00100) begin v.mdr_alu_n = 1'b1; v.mdr_en = 1'b1; end
        else begin v.busB = 3'b111; v.mdr_en = 1'b1; end
        step({nm, ".EX2"}, v);
        v = '0; v.instr_done = 1'b1;
        if (op == 5'b00100) begin
          v.busB = 3'b101; v.busC = 3'b111; v.bank_wr_en = 1'b1;
        end else begin
          v.wr_rdn = 1'b1;
        end
        step({nm, ".EX3"}, v);
      end
      5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011: begin
        case (op)
          5'b00110: v.selop = 3'b010;
          5'b00111: v.selop = 3'b011;
          5'b01000: v.selop = 3'b100;
          5'b01001: v.selop = 3'b101;
          5'b01010: v.selop = 3'b110;
          default:  begin v.selop = 3'b111; v.shamt = 2'b01; end
        endcase
        v.busB = 3'b111; v.busC = 3'b111; v.enaf = 1'b1;
        v.bank_wr_en = 1'b1; v.instr_done = 1'b1;
        step({nm, ".EX1"}, v);
      end
      5'b01100, 5'b01101, 5'b01110: begin
        if (taken) begin
          v.busB = 3'b010; v.busC = 3'b000; v.bank_wr_en = 1'b1;
          v.instr_done = 1'b1;
          step({nm, ".EX1"}, v);
        end
      end
      default: ;
    endcase
  endtask

  initial begin
    ctl_t v;
    rst = 1'b1; instruction = 5'b00000; C = 1'b0; N = 1'b0; P = 1'b0; Z = 1'b0;
    @(posedge clk);
    #1;
    step("rst.INIT_held", v_init());
    rst = 1'b0;
    step("rst.INIT", v_init());

    run_instr("NOP",      5'b00000, 1'b0, 1'b0, 1'b0);
    run_instr("MOV_DA",   5'b00001, 1'b0, 1'b0, 1'b0);
    run_instr("MOV_AD",   5'b00010, 1'b1, 1'b1, 1'b1);
    run_instr("MOV_AACC", 5'b00011, 1'b0, 1'b0, 1'b0);
    run_instr("ADD",      5'b00110, 1'b0, 1'b0, 1'b0);
    run_instr("SUB",      5'b00111, 1'b0, 1'b0, 1'b0);
    run_instr("AND",      5'b01000, 1'b0, 1'b0, 1'b0);
    run_instr("OR",       5'b01001, 1'b0, 1'b0, 1'b0);
    run_instr("XOR",      5'b01010, 1'b0, 1'b0, 1'b0);
    run_instr("SHL",      5'b01011, 1'b0, 1'b0, 1'b0);
    run_instr("LD",       5'b00100, 1'b0, 1'b0, 1'b0);
    run_instr("ST",       5'b00101, 1'b0, 1'b0, 1'b0);
    run_instr("JZ_tk",    5'b01100, 1'b0, 1'b0, 1'b1);
    run_instr("JZ_nt",    5'b01100, 1'b1, 1'b1, 1'b0);
    run_instr("JC_tk",    5'b01101, 1'b1, 1'b0, 1'b0);
    run_instr("JC_nt",    5'b01101, 1'b0, 1'b1, 1'b1);
    run_instr("JN_tk",    5'b01110, 1'b0, 1'b1, 1'b0);
    run_instr("JN_nt",    5'b01110, 1'b1, 1'b0, 1'b1);
    run_instr("ILL_10000", 5'b10000, 1'b0, 1'b0, 1'b0);
    run_instr("ILL_01111", 5'b01111, 1'b0, 1'b0, 1'b0);
    run_instr("ILL_11110", 5'b11110, 1'b0, 1'b0, 1'b0);

    // Reset asserted during EX2 of a load and held for two edges.
    instruction = 5'b00100;
    fetch("LDabort");
    step("LDabort.DEC", '0);
    v = '0; v.busB = 3'b010; v.mar_en = 1'b1;
    step("LDabort.EX1", v);
    rst = 1'b1;
    v = '0; v.mdr_alu_n = 1'b1; v.mdr_en = 1'b1;
    step("LDabort.EX2", v);
    step("LDabort.INIT_held", v_init());
    rst = 1'b0;
    step("LDabort.INIT", v_init());
    run_instr("NOP_after_rst", 5'b00000, 1'b0, 1'b0, 1'b0);

    run_instr("HALT", 5'b11111, 1'b0, 1'b0, 1'b0);
    instruction = 5'b00110; Z = 1'b1; C = 1'b1; N = 1'b1;
    for (int i = 0; i < 10; i++) step("HALT.hold", v_halt());
    rst = 1'b1;
    step("HALT.rst", v_halt());
    rst = 1'b0;
    step("HALT.INIT", v_init());
    v = '0; v.busB = 3'b000; v.mar_en = 1'b1;
    step("HALT.F0", v);

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) check_val("queue_drain", 23'(exp_q.size()), 23'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
